pipeline_sequencer: RTL

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_ctrl_pkg.sv | 12 +
 rtl/pipeline_sequencer_hazard_detect.sv | 13 +
 rtl/pipeline_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer.
package pipeline_ctrl_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use detector: the execute-stage load writes a register that decode reads.
module hazard_detect (
    input  logic       load_e,
    input  logic [4:0] rd_e,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    output logic       load_use
);

    // x0 is hard-wired to zero, so a load into it never creates a dependency.
    assign load_use = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline stall/flush sequencer with data-memory wait handling and timeout halt.
//   state       | meaning
//   ST_RUN      | normal flow, hazard rules active, dmem_req follows MemAccessM
//   ST_MEM_WAIT | pipeline frozen waiting for dmem_ready, timeout counter running
//   ST_HALT     | memory timed out, pipeline frozen until rst
module pipeline_sequencer
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MemAccessM,
    input  logic             dmem_ready,
    output logic             EnF,
    output logic             EnD,
    output logic             EnE,
    output logic             EnM,
    output logic             EnW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             dmem_req,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_q;
    logic              load_use;
    logic              freeze;

    hazard_detect u_hazard_detect (
        .load_e   (LoadE),
        .rd_e     (RdE),
        .rs1_d    (Rs1D),
        .rs2_d    (Rs2D),
        .load_use (load_use)
    );

    always_comb begin
        freeze   = 1'b0;
        dmem_req = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    dmem_req = MemAccessM;
                    freeze   = MemAccessM && !dmem_ready;
                end
                ST_MEM_WAIT: begin
                    dmem_req = 1'b1;
                    freeze   = !dmem_ready;
                end
                default: freeze = 1'b1;
            endcase
        end
    end

    // Freeze beats branch, branch beats load-use; reset forces the free-running pattern.
    always_comb begin
        EnF    = 1'b1;
        EnD    = 1'b1;
        EnE    = 1'b1;
        EnM    = 1'b1;
        EnW    = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (freeze) begin
            EnF = 1'b0;
            EnD = 1'b0;
            EnE = 1'b0;
            EnM = 1'b0;
            EnW = 1'b0;
        end else if (!rst && PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (!rst && load_use) begin
            EnF    = 1'b0;
            EnD    = 1'b0;
            FlushE = 1'b1;
        end
    end

    assign mem_timeout = timeout_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            timeout_q   <= 1'b0;
            stall_count <= '0;
        end else begin
            if (!EnF && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            case (state)
                ST_RUN: begin
                    if (MemAccessM && !dmem_ready) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= ST_RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= ST_HALT;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule
